// File: rtl/fb_pkg.sv
// Framebuffer geometry and arbiter grant encodings, shared by the arbiter,
// vga_controller and the capture block.
package fb_pkg;

  localparam int FB_WIDTH  = 176;
  localparam int FB_HEIGHT = 144;
  localparam int FB_SIZE   = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'b00,
    GRANT_READ  = 2'b01,
    GRANT_WRITE = 2'b10
  } grant_e;

  // Unsigned bounds test; callers zero-extend their address to 32 bits
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] limit);
    return (addr < limit);
  endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Synchronous write-buffer FIFO of {addr,data} entries. Pointers wrap modulo
// DEPTH, and level_next is exported so the owner can register a ready flag.
module fb_write_fifo #(
  parameter int AW    = 16,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic [LW-1:0] level_next
);

  logic [AW+DW-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             full_s;
  logic             push_s;
  logic             pop_s;

  assign full_s    = (level_r == LW'(DEPTH));
  assign empty     = (level_r == LW'(0));
  assign push_s    = push && !full_s;
  assign pop_s     = pop && !empty;
  assign head_addr = mem_r[rd_ptr_r][AW+DW-1:DW];
  assign head_data = mem_r[rd_ptr_r][DW-1:0];
  assign level     = level_r;

  // Next occupancy: simultaneous push and pop leaves the level unchanged
  always_comb begin
    level_next = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next = level_r + LW'(1);
      2'b01:   level_next = level_r - LW'(1);
      default: level_next = level_r;
    endcase
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(AW+DW){1'b0}};
      end
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      level_r  <= LW'(0);
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {push_addr, push_data};
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      level_r <= level_next;
    end
  end

endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer BRAM arbiter: VGA reads win every cycle with a fixed
// 2-cycle latency; camera writes are buffered and drain on read-free slots.
module framebuffer_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FB_SIZE    = fb_pkg::FB_SIZE
) (
  input  logic                          vga_clk_25,
  input  logic                          reset_n,
  input  logic                          rd_req,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          bram_en,
  output logic                          bram_we,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_din,
  input  logic [DATA_WIDTH-1:0]         bram_dout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          wr_range_err
);

  import fb_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  grant_e                grant_r;
  grant_e                grant_next_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] din_r;
  logic                  rd_in_range_s;
  logic                  wr_in_range_s;
  logic                  wr_accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_empty_s;
  logic [ADDR_WIDTH-1:0] head_addr_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic [LW-1:0]         level_s;
  logic [LW-1:0]         level_next_s;
  logic                  rd_v1_r;
  logic                  rd_ok1_r;
  logic                  rd_v2_r;
  logic                  rd_ok2_r;
  logic                  wr_ready_r;
  logic                  range_err_r;

  assign rd_in_range_s = addr_in_range(32'(rd_addr), 32'(FB_SIZE));
  assign wr_in_range_s = addr_in_range(32'(wr_addr), 32'(FB_SIZE));
  assign wr_accept_s   = wr_valid && wr_ready_r;
  assign push_s        = wr_accept_s && wr_in_range_s;
  assign pop_s         = (grant_next_s == GRANT_WRITE);

  fb_write_fifo #(
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (vga_clk_25),
    .rst_n      (reset_n),
    .push       (push_s),
    .push_addr  (wr_addr),
    .push_data  (wr_data),
    .pop        (pop_s),
    .head_addr  (head_addr_s),
    .head_data  (head_data_s),
    .empty      (fifo_empty_s),
    .level      (level_s),
    .level_next (level_next_s)
  );

  // Grant state register
  always_ff @(posedge vga_clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      grant_r <= GRANT_IDLE;
    end else begin
      grant_r <= grant_next_s;
    end
  end

  // Next grant: an out-of-range read leaves the slot free for a write
  always_comb begin
    grant_next_s = GRANT_IDLE;
    if (rd_req && rd_in_range_s) begin
      grant_next_s = GRANT_READ;
    end else if (!fifo_empty_s) begin
      grant_next_s = GRANT_WRITE;
    end else begin
      grant_next_s = GRANT_IDLE;
    end
  end

  // BRAM strobes decoded from the registered grant
  always_comb begin
    bram_en = 1'b0;
    bram_we = 1'b0;
    case (grant_r)
      GRANT_READ: begin
        bram_en = 1'b1;
        bram_we = 1'b0;
      end
      GRANT_WRITE: begin
        bram_en = 1'b1;
        bram_we = 1'b1;
      end
      default: begin
        bram_en = 1'b0;
        bram_we = 1'b0;
      end
    endcase
  end

  // BRAM address/data registers, zeroed on idle slots
  always_ff @(posedge vga_clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      addr_r <= {ADDR_WIDTH{1'b0}};
      din_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      case (grant_next_s)
        GRANT_READ: begin
          addr_r <= rd_addr;
          din_r  <= {DATA_WIDTH{1'b0}};
        end
        GRANT_WRITE: begin
          addr_r <= head_addr_s;
          din_r  <= head_data_s;
        end
        default: begin
          addr_r <= {ADDR_WIDTH{1'b0}};
          din_r  <= {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Two-stage read-valid pipeline carrying the in-range qualifier
  always_ff @(posedge vga_clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1_r  <= 1'b0;
      rd_ok1_r <= 1'b0;
      rd_v2_r  <= 1'b0;
      rd_ok2_r <= 1'b0;
    end else begin
      rd_v1_r  <= rd_req;
      rd_ok1_r <= rd_req && rd_in_range_s;
      rd_v2_r  <= rd_v1_r;
      rd_ok2_r <= rd_ok1_r;
    end
  end

  // Write-side status: ready tracks next occupancy, range error is sticky
  always_ff @(posedge vga_clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ready_r  <= 1'b0;
      range_err_r <= 1'b0;
    end else begin
      wr_ready_r  <= (level_next_s < LW'(FIFO_DEPTH));
      range_err_r <= range_err_r || (wr_accept_s && !wr_in_range_s);
    end
  end

  assign bram_addr    = addr_r;
  assign bram_din     = din_r;
  assign rd_valid     = rd_v2_r;
  assign rd_data      = rd_ok2_r ? bram_dout : {DATA_WIDTH{1'b0}};
  assign wr_ready     = wr_ready_r;
  assign fifo_level   = level_s;
  assign wr_range_err = range_err_r;

endmodule
